mc_control_unit: RTL and testbench

Multicycle sequencer for the MIPS core. Drives the 3-bit `state` that the instruction field decoder uses to latch opcode/rs/rt/rd/funct in ID, and emits all per-cycle datapath strobes: PC, IR, memory, register file and ALU control. Handles variable-latency memory through a ready handshake and halts on the HALT opcode.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_alu_dec.sv | 54 +++++
 rtl/mc_control_unit.sv | 159 +++++++++++++++
 tb/tb_mc_control_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants and the datapath select codes driven by the sequencer.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RS     = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_src_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // R-type functs that go through EXE/WB (jr is handled in ID).
    function automatic logic is_rtype_alu(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_SLL);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decode: drives alu_op, operand-B select and extension mode while the
// datapath is computing (EXE through WB); idle states get ADD on rt with zero extend.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [2:0] state,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic       ext_sel
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path can infer a latch.
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        if (state == ST_EXE || state == ST_MEM || state == ST_WB) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_SUB:  alu_op = ALU_SUB;
                        FN_AND:  alu_op = ALU_AND;
                        FN_OR:   alu_op = ALU_OR;
                        FN_SLT:  alu_op = ALU_SLT;
                        FN_SLL:  alu_op = ALU_SLL;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                OP_BEQ, OP_BNE: begin
                    alu_op  = ALU_SUB;
                    ext_sel = 1'b1;
                end
                OP_ADDI, OP_LW, OP_SW: begin
                    alu_op    = ALU_ADD;
                    alu_src_b = 1'b1;
                    ext_sel   = 1'b1;
                end
                OP_SLTI: begin
                    alu_op    = ALU_SLT;
                    alu_src_b = 1'b1;
                    ext_sel   = 1'b1;
                end
                OP_ORI: begin
                    alu_op    = ALU_OR;
                    alu_src_b = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS sequencer: IF/ID/EXE/MEM/WB/HALT FSM with combinational strobes.
// Define MC_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        ir_wr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        iord,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic        alu_src_b,
    output logic [2:0]  alu_op,
    output logic        ext_sel,
    output logic        illegal,
    output logic        halted
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t state_r;
    state_t state_nxt;

    assign state = state_r;

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST) state_r <= ST_IF;
        else     state_r <= state_nxt;
    end

    mc_alu_dec u_alu_dec (
        .opcode    (opcode),
        .funct     (funct),
        .state     (state_r),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .ext_sel   (ext_sel)
    );

    always_comb begin
        state_nxt = state_r;
        pc_wr     = 1'b0;
        pc_src    = PC_PLUS4;
        ir_wr     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        iord      = 1'b0;
        reg_wr    = 1'b0;
        reg_dst   = DST_RT;
        wb_src    = WB_ALU;
        illegal   = 1'b0;
        halted    = 1'b0;
        // Gating on RST keeps strobes quiet even when opcode/funct are undriven in reset.
        if (!RST) begin
            case (state_r)
                ST_IF: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_wr     = 1'b1;
                        pc_wr     = 1'b1;
                        state_nxt = ST_ID;
                    end
                end
                ST_ID: begin
                    state_nxt = ST_IF;
                    if (opcode == HALT_OP) begin
                        state_nxt = ST_HALT;
                    end else begin
                        case (opcode)
                            OP_J: begin
                                pc_wr  = 1'b1;
                                pc_src = PC_JUMP;
                            end
                            OP_JAL: begin
                                pc_wr   = 1'b1;
                                pc_src  = PC_JUMP;
                                reg_wr  = 1'b1;
                                reg_dst = DST_RA;
                                wb_src  = WB_PC4;
                            end
                            OP_RTYPE: begin
                                if (funct == FN_JR) begin
                                    pc_wr  = 1'b1;
                                    pc_src = PC_RS;
                                end else if (is_rtype_alu(funct)) begin
                                    state_nxt = ST_EXE;
                                end else begin
                                    illegal = 1'b1;
                                end
                            end
                            OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ORI, OP_LW, OP_SW:
                                state_nxt = ST_EXE;
                            default: illegal = 1'b1;
                        endcase
                    end
                end
                ST_EXE: begin
                    case (opcode)
                        OP_BEQ: begin
                            pc_wr     = zero;
                            pc_src    = PC_BRANCH;
                            state_nxt = ST_IF;
                        end
                        OP_BNE: begin
                            pc_wr     = !zero;
                            pc_src    = PC_BRANCH;
                            state_nxt = ST_IF;
                        end
                        OP_LW, OP_SW: state_nxt = ST_MEM;
                        default:      state_nxt = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    iord = 1'b1;
                    if (opcode == OP_LW) mem_rd = 1'b1;
                    else                 mem_wr = 1'b1;
                    if (mem_ready) state_nxt = (opcode == OP_LW) ? ST_WB : ST_IF;
                end
                ST_WB: begin
                    reg_wr    = 1'b1;
                    state_nxt = ST_IF;
                    if (opcode == OP_RTYPE)  reg_dst = DST_RD;
                    else if (opcode == OP_LW) wb_src = WB_MEM;
                end
                ST_HALT: halted = 1'b1;
                default: state_nxt = ST_IF;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else if (state_r != ST_HALT) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state_r != ST_IF && state_nxt == ST_IF) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-cycle expectations are queued per
// instruction and popped/compared each cycle against the DUT strobes.
module tb_mc_control_unit;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

    localparam logic [5:0] OP_R    = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010, OP_ORI  = 6'b001101, OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011, OP_HALT = 6'b111111, OP_BAD  = 6'b010001;
    localparam logic [5:0] FN_ADD  = 6'b100000, FN_JR   = 6'b001000, FN_BAD  = 6'b000001;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] state;
    logic       pc_wr, ir_wr, mem_rd, mem_wr, iord, reg_wr;
    logic [1:0] pc_src, reg_dst, wb_src;
    logic       alu_src_b, ext_sel, illegal, halted;
    logic [2:0] alu_op;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mc_control_unit #(.HALT_OP(OP_HALT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .state     (state),
        .pc_wr     (pc_wr),
        .pc_src    (pc_src),
        .ir_wr     (ir_wr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .iord      (iord),
        .reg_wr    (reg_wr),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .ext_sel   (ext_sel),
        .illegal   (illegal),
        .halted    (halted)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       ir_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       illegal;
        logic       halted;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       z;
        outs_t      v;
        outs_t      care;
        logic       done;
    } exp_t;

    outs_t obs;
    assign obs = {state, pc_wr, pc_src, ir_wr, mem_rd, mem_wr, iord, reg_wr,
                  reg_dst, wb_src, alu_src_b, alu_op, ext_sel, illegal, halted};

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned exp_cycles = 0;
    int unsigned exp_instr = 0;

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o;
        o       = '0;
        o.state = st;
        return o;
    endfunction

    // Selects only matter when their strobe is active; alu: 0 ignore, 1 op+src_b, 2 +ext.
    function automatic outs_t care_of(input outs_t v, input int alu);
        outs_t c;
        c = '1;
        if (!v.pc_wr) c.pc_src = '0;
        if (!v.reg_wr) begin
            c.reg_dst = '0;
            c.wb_src  = '0;
        end
        if (!v.mem_rd && !v.mem_wr) c.iord = 1'b0;
        if (alu < 1) begin
            c.alu_op    = '0;
            c.alu_src_b = 1'b0;
        end
        if (alu < 2) c.ext_sel = 1'b0;
        return c;
    endfunction

    task automatic push(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic z, input outs_t v, input int alu,
                        input logic done);
        exp_t e;
        e.name = nm; e.op = op; e.fn = fn; e.rdy = rdy; e.z = z;
        e.v = v; e.care = care_of(v, alu); e.done = done;
        sb.push_back(e);
    endtask

    task automatic push_fetch(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input int waits);
        outs_t v;
        v = blank(S_IF);
        v.mem_rd = 1'b1;
        for (int i = 0; i < waits; i++) push({nm, ".ifwait"}, op, fn, 1'b0, 1'b0, v, 0, 1'b0);
        v.ir_wr = 1'b1;
        v.pc_wr = 1'b1;
        push({nm, ".if"}, op, fn, 1'b1, 1'b0, v, 0, 1'b0);
    endtask

    // Drives the head record's inputs for one cycle and returns what the DUT showed.
    task automatic step(output exp_t e, output outs_t o);
        e = sb.pop_front();
        opcode = e.op; funct = e.fn; mem_ready = e.rdy; zero = e.z;
        #1;
        o = obs;
        if (e.v.state != S_HALT) exp_cycles++;
        if (e.done) exp_instr++;
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset;
        outs_t o, v;
        RST = 1'b1; opcode = 'z; funct = 'x; mem_ready = 1'b1; zero = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        o = obs; v = blank(S_IF);
        total++;
        if (((o ^ v) & care_of(v, 0)) !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", o, v);
        end
`ifdef MC_PERF_CNT_EN
        total++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
        end
`endif
        RST = 1'b0; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b0; zero = 1'b0;
        exp_cycles = 0; exp_instr = 0;
    endtask

    task automatic test_add;
        exp_t e; outs_t o, v;
        push_fetch("add", OP_R, FN_ADD, 0);
        push("add.id", OP_R, FN_ADD, 1'b1, 1'b0, blank(S_ID), 0, 1'b0);
        push("add.exe", OP_R, FN_ADD, 1'b1, 1'b0, blank(S_EXE), 1, 1'b0);
        v = blank(S_WB); v.reg_wr = 1'b1; v.reg_dst = 2'd1; v.wb_src = 2'd0;
        push("add.wb", OP_R, FN_ADD, 1'b1, 1'b0, v, 0, 1'b1);
        while (sb.size() > 0) begin
            step(e, o);
            total++;
            if (((o ^ e.v) & e.care) !== '0) begin
                bad++; $display("FAIL %s: got %h want %h care %h", e.name, o, e.v, e.care);
            end
        end
    endtask

    task automatic test_lw_wait;
        exp_t e; outs_t o, v;
        push_fetch("lw", OP_LW, 6'd0, 0);
        push("lw.id", OP_LW, 6'd0, 1'b0, 1'b0, blank(S_ID), 0, 1'b0);
        v = blank(S_EXE); v.alu_op = 3'd0; v.alu_src_b = 1'b1; v.ext_sel = 1'b1;
        push("lw.exe", OP_LW, 6'd0, 1'b0, 1'b0, v, 2, 1'b0);
        v = blank(S_MEM); v.mem_rd = 1'b1; v.iord = 1'b1;
        push("lw.mem0", OP_LW, 6'd0, 1'b0, 1'b0, v, 0, 1'b0);
        push("lw.mem1", OP_LW, 6'd0, 1'b0, 1'b0, v, 0, 1'b0);
        push("lw.mem2", OP_LW, 6'd0, 1'b1, 1'b0, v, 0, 1'b0);
        v = blank(S_WB); v.reg_wr = 1'b1; v.reg_dst = 2'd0; v.wb_src = 2'd1;
        push("lw.wb", OP_LW, 6'd0, 1'b1, 1'b0, v, 0, 1'b1);
        while (sb.size() > 0) begin
            step(e, o);
            total++;
            if (((o ^ e.v) & e.care) !== '0) begin
                bad++; $display("FAIL %s: got %h want %h care %h", e.name, o, e.v, e.care);
            end
        end
    endtask

    task automatic test_branch;
        exp_t e; outs_t o, v;
        logic [5:0] ops[4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic       zs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            push_fetch("br", ops[i], 6'd0, 0);
            push("br.id", ops[i], 6'd0, 1'b1, zs[i], blank(S_ID), 0, 1'b0);
            v = blank(S_EXE); v.alu_op = 3'd1; v.alu_src_b = 1'b0;
            v.pc_wr = (ops[i] == OP_BEQ) ? zs[i] : !zs[i];
            v.pc_src = 2'd1;
            push("br.exe", ops[i], 6'd0, 1'b1, zs[i], v, 1, 1'b1);
        end
        while (sb.size() > 0) begin
            step(e, o);
            total++;
            if (((o ^ e.v) & e.care) !== '0) begin
                bad++; $display("FAIL %s: got %h want %h care %h", e.name, o, e.v, e.care);
            end
        end
    endtask

    task automatic test_jumps;
        exp_t e; outs_t o, v;
        push_fetch("j", OP_J, 6'd0, 0);
        v = blank(S_ID); v.pc_wr = 1'b1; v.pc_src = 2'd2;
        push("j.id", OP_J, 6'd0, 1'b1, 1'b0, v, 0, 1'b1);
        push_fetch("jal", OP_JAL, 6'd0, 0);
        v.reg_wr = 1'b1; v.reg_dst = 2'd2; v.wb_src = 2'd2;
        push("jal.id", OP_JAL, 6'd0, 1'b1, 1'b0, v, 0, 1'b1);
        push_fetch("jr", OP_R, FN_JR, 0);
        v = blank(S_ID); v.pc_wr = 1'b1; v.pc_src = 2'd3;
        push("jr.id", OP_R, FN_JR, 1'b1, 1'b0, v, 0, 1'b1);
        while (sb.size() > 0) begin
            step(e, o);
            total++;
            if (((o ^ e.v) & e.care) !== '0) begin
                bad++; $display("FAIL %s: got %h want %h care %h", e.name, o, e.v, e.care);
            end
        end
`ifdef MC_PERF_CNT_EN
        total++;
        if (cycle_cnt !== exp_cycles || instr_cnt !== exp_instr) begin
            bad++;
            $display("FAIL jumps_counters: got %0d/%0d want %0d/%0d",
                     cycle_cnt, instr_cnt, exp_cycles, exp_instr);
        end
`endif
    endtask

    task automatic test_ialu;
        exp_t e; outs_t o, v;
        logic [5:0] ops[3]  = '{OP_ORI, OP_SLTI, OP_ADDI};
        logic [2:0] alus[3] = '{3'd3, 3'd4, 3'd0};
        logic       exts[3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            push_fetch("ialu", ops[i], 6'd0, 0);
            push("ialu.id", ops[i], 6'd0, 1'b1, 1'b0, blank(S_ID), 0, 1'b0);
            v = blank(S_EXE); v.alu_op = alus[i]; v.alu_src_b = 1'b1; v.ext_sel = exts[i];
            push("ialu.exe", ops[i], 6'd0, 1'b1, 1'b0, v, 2, 1'b0);
            v = blank(S_WB); v.reg_wr = 1'b1; v.reg_dst = 2'd0; v.wb_src = 2'd0;
            push("ialu.wb", ops[i], 6'd0, 1'b1, 1'b0, v, 0, 1'b1);
        end
        while (sb.size() > 0) begin
            step(e, o);
            total++;
            if (((o ^ e.v) & e.care) !== '0) begin
                bad++; $display("FAIL %s: got %h want %h care %h", e.name, o, e.v, e.care);
            end
        end
    endtask

    task automatic test_sw_abort;
        exp_t e; outs_t o, v;
        for (int k = 0; k < 2; k++) begin
            push_fetch("sw", OP_SW, 6'd0, 1 - k);
            push("sw.id", OP_SW, 6'd0, 1'b1, 1'b0, blank(S_ID), 0, 1'b0);
            v = blank(S_EXE); v.alu_op = 3'd0; v.alu_src_b = 1'b1; v.ext_sel = 1'b1;
            push("sw.exe", OP_SW, 6'd0, 1'b1, 1'b0, v, 2, 1'b0);
            v = blank(S_MEM); v.mem_wr = 1'b1; v.iord = 1'b1;
            push("sw.mem0", OP_SW, 6'd0, 1'b0, 1'b0, v, 0, 1'b0);
            if (k == 0) push("sw.mem1", OP_SW, 6'd0, 1'b1, 1'b0, v, 0, 1'b1);
        end
        while (sb.size() > 0) begin
            step(e, o);
            total++;
            if (((o ^ e.v) & e.care) !== '0) begin
                bad++; $display("FAIL %s: got %h want %h care %h", e.name, o, e.v, e.care);
            end
        end
        total++;
        if (state !== S_MEM || mem_wr !== 1'b1) begin
            bad++; $display("FAIL sw_wait_hold: got state=%0d mem_wr=%b want 3/1", state, mem_wr);
        end
        RST = 1'b1;
        #1;
        o = obs; v = blank(S_IF);
        total++;
        if (((o ^ v) & care_of(v, 0)) !== '0) begin
            bad++; $display("FAIL sw_async_reset: got %h want %h", o, v);
        end
`ifdef MC_PERF_CNT_EN
        total++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            bad++; $display("FAIL abort_counters: got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
        end
`endif
        @(negedge CLK);
        RST = 1'b0;
        #1;
        exp_cycles = 0; exp_instr = 0;
    endtask

    task automatic test_illegal_halt;
        exp_t e; outs_t o, v;
        push_fetch("bad_op", OP_BAD, 6'd0, 0);
        v = blank(S_ID); v.illegal = 1'b1;
        push("bad_op.id", OP_BAD, 6'd0, 1'b1, 1'b0, v, 0, 1'b1);
        push_fetch("bad_fn", OP_R, FN_BAD, 0);
        push("bad_fn.id", OP_R, FN_BAD, 1'b1, 1'b0, v, 0, 1'b1);
        push_fetch("halt", OP_HALT, 6'd0, 0);
        push("halt.id", OP_HALT, 6'd0, 1'b1, 1'b0, blank(S_ID), 0, 1'b0);
        v = blank(S_HALT); v.halted = 1'b1;
        for (int i = 0; i < 12; i++) push("halt.park", OP_HALT, 6'd0, i[0], 1'b1, v, 0, 1'b0);
        while (sb.size() > 0) begin
            step(e, o);
            total++;
            if (((o ^ e.v) & e.care) !== '0) begin
                bad++; $display("FAIL %s: got %h want %h care %h", e.name, o, e.v, e.care);
            end
        end
`ifdef MC_PERF_CNT_EN
        total++;
        if (cycle_cnt !== exp_cycles || instr_cnt !== exp_instr) begin
            bad++;
            $display("FAIL halt_counters: got %0d/%0d want %0d/%0d",
                     cycle_cnt, instr_cnt, exp_cycles, exp_instr);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jumps();
        test_ialu();
        test_sw_abort();
        test_illegal_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
